// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-ported memory interface between the I-cache and D-cache
// buses. D-side wins ties, but after D_MAX consecutive D grants with an I
// request waiting, I gets the port. A watchdog aborts an access that sees no
// mem_ack within TIMEOUT cycles and answers the owner with ERR_DATA.
//
// Ports
//   Clk, Rst                  clock, synchronous active-high reset
//   Icache_bus_out / Dcache_bus_out  requests {req, we, addr[31:0], wdata[31:0]}
//   Icache_bus_in  / Dcache_bus_in   responses {ack, rdata[31:0]}, ack is 1 cycle
//   mem_req/we/addr/wdata     memory request, held until mem_ack
//   mem_ack, mem_rdata        memory completion pulse and read data
//   o_busy                    high in BUSY or RESP
//   o_grant                   01 = I owns the port, 10 = D owns it, 00 = idle
//   o_timeout_err             sticky watchdog flag, cleared only by Rst
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | port free, both request bits sampled for arbitration
// S_BUSY | access outstanding at memory, mem_* fields held
// S_RESP | one-cycle ack pulse to the owner, then back to idle
module mem_bus_arbiter #(
  parameter int unsigned D_MAX    = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [65:0] Icache_bus_out,
  output logic [32:0] Icache_bus_in,
  input  logic [65:0] Dcache_bus_out,
  output logic [32:0] Dcache_bus_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        o_busy,
  output logic [1:0]  o_grant,
  output logic        o_timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] DMAX_C   = 4'(D_MAX);
  // Abort fires in the TIMEOUT-th BUSY cycle, i.e. when TIMEOUT-1 cycles
  // have already gone by without mem_ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        own_d_q, own_d_d;  // 1 = D owns the current access
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [32:0] ibus_q, ibus_d;
  logic [32:0] dbus_q, dbus_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        terr_q, terr_d;

  logic        i_req, d_req;
  logic [31:0] resp_data;

  assign i_req     = Icache_bus_out[65];
  assign d_req     = Dcache_bus_out[65];
  assign resp_data = mem_we_q ? 32'h0 : mem_rdata;

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ibus_d      = ibus_q;
    dbus_d      = dbus_q;
    grant_d     = grant_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if (!i_req) starve_d = '0;
        if (d_req && (!i_req || starve_q < DMAX_C)) begin
          own_d_d     = 1'b1;
          grant_d     = 2'b10;
          mem_we_d    = Dcache_bus_out[64];
          mem_addr_d  = Dcache_bus_out[63:32];
          mem_wdata_d = Dcache_bus_out[31:0];
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          state_d     = S_BUSY;
          // D can only win over a waiting I while below D_MAX, so this
          // increment saturates at D_MAX by construction.
          if (i_req) starve_d = starve_q + 4'd1;
        end else if (i_req) begin
          own_d_d     = 1'b0;
          grant_d     = 2'b01;
          mem_we_d    = Icache_bus_out[64];
          mem_addr_d  = Icache_bus_out[63:32];
          mem_wdata_d = Icache_bus_out[31:0];
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          starve_d    = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (own_d_q) dbus_d = {1'b1, resp_data};
          else         ibus_d = {1'b1, resp_data};
        end else if (tmo_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          terr_d    = 1'b1;
          state_d   = S_RESP;
          if (own_d_q) dbus_d = {1'b1, ERR_DATA};
          else         ibus_d = {1'b1, ERR_DATA};
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_RESP: begin
        ibus_d  = '0;
        dbus_d  = '0;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ibus_q      <= '0;
      dbus_q      <= '0;
      grant_q     <= 2'b00;
      starve_q    <= '0;
      tmo_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ibus_q      <= ibus_d;
      dbus_q      <= dbus_d;
      grant_q     <= grant_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      terr_q      <= terr_d;
    end
  end

  assign Icache_bus_in = ibus_q;
  assign Dcache_bus_in = dbus_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign o_grant       = grant_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int          DM   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [65:0] ib_o, db_o;
  logic [32:0] ib_i, db_i;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        o_busy, o_timeout_err;
  logic [1:0]  o_grant;

  always #5 Clk = ~Clk;

  mem_bus_arbiter #(.D_MAX(DM), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .Clk(Clk), .Rst(Rst),
    .Icache_bus_out(ib_o), .Icache_bus_in(ib_i),
    .Dcache_bus_out(db_o), .Dcache_bus_in(db_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_busy(o_busy), .o_grant(o_grant), .o_timeout_err(o_timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: one outstanding access, its age, and a pending
  // response that is visible for one cycle.
  bit          m_act, m_resp, m_err;
  int          m_own;   // 0 none, 1 I, 2 D
  int          m_age;   // BUSY cycles already waited without mem_ack
  int          m_run;   // D wins in a row while I was waiting
  logic [31:0] m_data, m_addr, m_wdata;
  logic        m_we;
  int          glog[$];

  bit auto_mode = 0;
  int mcnt = -1, mdly = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ir, dr;
    int win;
    if (Rst) begin
      m_act = 0; m_resp = 0; m_err = 0; m_own = 0; m_age = 0; m_run = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_data = 0;
    end else if (m_resp) begin
      m_resp = 0; m_own = 0;
    end else if (m_act) begin
      if (mem_ack) begin
        m_act = 0; m_resp = 1; m_data = m_we ? 32'h0 : mem_rdata;
      end else if (m_age + 1 >= TMO) begin
        m_act = 0; m_resp = 1; m_data = ERRD; m_err = 1;
      end else m_age++;
    end else begin
      ir = ib_o[65]; dr = db_o[65]; win = 0;
      if (dr && (!ir || m_run < DM)) win = 2;
      else if (ir) win = 1;
      if (!ir) m_run = 0;
      if (win == 2 && ir) m_run = (m_run < DM) ? m_run + 1 : DM;
      if (win == 1) m_run = 0;
      if (win != 0) begin
        m_we    = (win == 2) ? db_o[64]    : ib_o[64];
        m_addr  = (win == 2) ? db_o[63:32] : ib_o[63:32];
        m_wdata = (win == 2) ? db_o[31:0]  : ib_o[31:0];
        m_act = 1; m_age = 0; m_own = win;
        glog.push_back(win);
      end
    end
  endtask

  task automatic compare();
    logic [32:0] ei, ed;
    logic [1:0]  eg;
    ei = (m_resp && m_own == 1) ? {1'b1, m_data} : 33'h0;
    ed = (m_resp && m_own == 2) ? {1'b1, m_data} : 33'h0;
    eg = (m_act || m_resp) ? ((m_own == 2) ? 2'b10 : 2'b01) : 2'b00;
    chk("mem_req", 64'(mem_req), 64'(m_act));
    chk("icache_bus_in", 64'(ib_i), 64'(ei));
    chk("dcache_bus_in", 64'(db_i), 64'(ed));
    chk("o_grant", 64'(o_grant), 64'(eg));
    chk("o_busy", 64'(o_busy), 64'(m_act || m_resp));
    chk("o_timeout_err", 64'(o_timeout_err), 64'(m_err));
    if (m_act) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
  endtask

  function automatic logic [65:0] rnd_req();
    logic [31:0] a, w;
    logic        we;
    a  = $urandom;
    w  = $urandom;
    we = 1'($urandom_range(0, 1));
    return {1'b1, we, a, w};
  endfunction

  task automatic drive();
    Rst = ($urandom_range(0, 499) == 0);
    mem_ack = 1'b0;
    if (mem_req) begin
      if (mcnt < 0) begin
        mdly = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 10) : $urandom_range(0, 4);
        mcnt = 0;
      end
      if (mcnt == mdly) begin mem_ack = 1'b1; mem_rdata = $urandom; end
      mcnt++;
    end else begin
      mcnt = -1;
      if ($urandom_range(0, 15) == 0) begin mem_ack = 1'b1; mem_rdata = $urandom; end
    end
    if (ib_i[32]) ib_o = ($urandom_range(0, 1) == 1) ? rnd_req() : 66'h0;
    else if (!ib_o[65] && $urandom_range(0, 3) == 0) ib_o = rnd_req();
    else if (ib_o[65] && o_grant == 2'b01 && $urandom_range(0, 15) == 0) ib_o[63:0] = {$urandom, $urandom};
    else if (ib_o[65] && $urandom_range(0, 63) == 0) ib_o[65] = 1'b0;
    if (db_i[32]) db_o = ($urandom_range(0, 1) == 1) ? rnd_req() : 66'h0;
    else if (!db_o[65] && $urandom_range(0, 2) == 0) db_o = rnd_req();
    else if (db_o[65] && o_grant == 2'b10 && $urandom_range(0, 15) == 0) db_o[63:0] = {$urandom, $urandom};
    else if (db_o[65] && $urandom_range(0, 63) == 0) db_o[65] = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    #1;
    compare();
    if (auto_mode) drive();
  endtask

  initial begin
    int n, base;
    int seq[$];
    logic [1:0] prev;
    int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    Rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    ib_o = {1'b1, 1'b0, 32'h200, 32'h0};
    db_o = {1'b1, 1'b0, 32'h300, 32'h0};

    // Reset held with both requesting
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_grant", 64'(o_grant), 64'h0);
    chk("rst_bus", 64'({ib_i, db_i}), 64'h0);
    chk("rst_busy_err", 64'({o_busy, o_timeout_err}), 64'h0);
    Rst = 1'b0;
    step();
    chk("first_grant_is_d", 64'(o_grant), 64'h2);
    chk("first_mem_req", 64'(mem_req), 64'h1);
    chk("first_addr", 64'(mem_addr), 64'h300);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    chk("first_d_resp", 64'(db_i), 64'h1_1111_1111);
    mem_ack = 1'b0; db_o = '0; ib_o = '0;
    step();
    step();

    // Single I read, ack three cycles after mem_req
    ib_o = {1'b1, 1'b0, 32'h100, 32'h0};
    step();
    chk("i_read_addr", 64'(mem_addr), 64'h100);
    chk("i_read_grant", 64'(o_grant), 64'h1);
    repeat (3) step();
    chk("i_read_no_early_ack", 64'(ib_i), 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    chk("i_read_resp", 64'(ib_i), 64'h1_1234_5678);
    chk("i_read_d_quiet", 64'(db_i), 64'h0);
    mem_ack = 1'b0; ib_o = '0;
    step();
    chk("i_read_ack_one_cycle", 64'(ib_i), 64'h0);

    // D write, immediate ack
    db_o = {1'b1, 1'b1, 32'h40, 32'hA5A5A5A5};
    step();
    chk("d_write_we", 64'(mem_we), 64'h1);
    chk("d_write_addr", 64'(mem_addr), 64'h40);
    chk("d_write_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    step();
    chk("d_write_resp", 64'(db_i), 64'h1_0000_0000);
    mem_ack = 1'b0; db_o = '0;
    step();

    // Both requesting continuously: starvation guard ordering
    ib_o = {1'b1, 1'b0, 32'h1000, 32'h0};
    db_o = {1'b1, 1'b0, 32'h2000, 32'h0};
    base = glog.size();
    prev = o_grant;
    n = 0;
    while (seq.size() < 10 && n < 120) begin
      step();
      if (o_grant != 2'b00 && prev == 2'b00) seq.push_back((o_grant == 2'b10) ? 2 : 1);
      prev = o_grant;
      mem_ack = mem_req;
      mem_rdata = $urandom;
      n++;
    end
    chk("grant_seq_len", 64'(seq.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < seq.size()) chk($sformatf("grant_seq_dut[%0d]", k), 64'(seq[k]), 64'(exp_seq[k]));
      if (base + k < glog.size()) chk($sformatf("grant_seq_model[%0d]", k), 64'(glog[base + k]), 64'(exp_seq[k]));
    end
    ib_o = '0; db_o = '0;
    repeat (12) begin mem_ack = mem_req; step(); end
    mem_ack = 1'b0;
    step();

    // Watchdog: no mem_ack
    ib_o = {1'b1, 1'b0, 32'h500, 32'h0};
    step();
    n = 0;
    while (mem_req === 1'b1 && n < 30) begin n++; step(); end
    chk("timeout_req_cycles", 64'(n), 64'(TMO));
    chk("timeout_resp", 64'(ib_i), {31'h0, 1'b1, ERRD});
    chk("timeout_flag", 64'(o_timeout_err), 64'h1);
    ib_o = '0;
    step();
    db_o = {1'b1, 1'b0, 32'h600, 32'h0};
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    chk("after_tmo_ok_resp", 64'(db_i), 64'h1_0BAD_F00D);
    chk("timeout_flag_sticky", 64'(o_timeout_err), 64'h1);
    mem_ack = 1'b0; db_o = '0;
    step();

    // Reset mid-BUSY, late ack afterwards
    db_o = {1'b1, 1'b0, 32'h700, 32'h0};
    step();
    step();
    Rst = 1'b1;
    step();
    chk("midrst_mem_req", 64'(mem_req), 64'h0);
    chk("midrst_grant_busy", 64'({o_grant, o_busy}), 64'h0);
    chk("midrst_err_cleared", 64'(o_timeout_err), 64'h0);
    Rst = 1'b0; db_o = '0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    step();
    mem_ack = 1'b0;
    step();
    chk("late_ack_ignored", 64'({ib_i, db_i}), 64'h0);
    chk("late_ack_no_req", 64'(mem_req), 64'h0);

    // Randomized traffic
    auto_mode = 1;
    drive();
    repeat (4000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the instruction-cache bus and the data-cache bus that leave the processor core.
- Registered grant/response FSM. D-side has priority. A starvation counter guarantees I-side progress, and a timeout watchdog covers a hung memory.
- Sits between the processor's Icache_bus_out/Icache_bus_in and Dcache_bus_out/Dcache_bus_in and a single-ported memory/interconnect.

Parameters:
- D_MAX, 4: maximum consecutive D-side grants while an I-side request is pending (1..15).
- TIMEOUT, 255: cycles in BUSY without mem_ack before the access is aborted (1..255, 8-bit counter).
- ERR_DATA, 32'hDEADBEEF: read data returned on an aborted access.

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Icache_bus_out  in  66  I request: [65]=req, [64]=we, [63:32]=addr, [31:0]=wdata
- Icache_bus_in  out  33  I response: [32]=ack (1-cycle pulse), [31:0]=rdata
- Dcache_bus_out  in  66  D request, same format as I
- Dcache_bus_in  out  33  D response, same format as I
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  access address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- o_busy  out  1  high in BUSY or RESP
- o_grant  out  2  01=I owns the port, 10=D owns it, 00=idle
- o_timeout_err  out  1  sticky timeout flag; cleared only by Rst

Behaviour:
- Reset (Rst=1 at an edge), regardless of current state:
  - state=IDLE.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both bus_in=33'b0, o_grant=00, o_busy=0, o_timeout_err=0.
  - Internal: starve_cnt=0, tmo_cnt=0.
  - An in-flight mem_ack arriving after reset is ignored.
- Requester contract:
  - Hold req=1 with we/addr/wdata stable until its ack.
  - In the cycle after ack, either drop req or present a new request.
- IDLE:
  - Samples both req bits.
  - If neither is set, stay in IDLE.
  - D only pending: grant D.
  - I only pending: grant I.
  - Both pending: grant D if starve_cnt<D_MAX, else grant I.
  - On grant, latch we/addr/wdata of the winner into the mem_* registers, set mem_req=1, set o_grant, clear tmo_cnt, go to BUSY.
  - mem_req is first visible the cycle after the request is sampled (1-cycle arbitration latency).
- starve_cnt:
  - Incremented on a D grant made while I req=1, saturating at D_MAX.
  - Cleared on any I grant, or in any IDLE cycle with I req=0.
- BUSY:
  - mem_req and all mem_* outputs held stable.
  - Each cycle without mem_ack, tmo_cnt increments.
  - On mem_ack: mem_req=0; the owner's bus_in becomes {1'b1, mem_rdata}, or {1'b1, 32'h0} for a write; go to RESP. The owner sees ack the cycle after mem_ack.
  - If tmo_cnt reaches TIMEOUT with no mem_ack: mem_req=0; the owner's bus_in becomes {1'b1, ERR_DATA}; o_timeout_err=1; go to RESP.
  - mem_ack in the same cycle as the timeout: mem_ack wins and no error is flagged.
- RESP (exactly one cycle):
  - The ack pulse is visible.
  - The non-owner's bus_in stays 33'b0.
  - Next state IDLE with o_grant=00 and both bus_in=0. Requests present then are treated as new.
  - Back-to-back throughput is one access per (mem latency + 3) cycles.
- Non-owner and idle responses:
  - Non-owner bus_in is always 33'b0.
  - A mem_ack seen in IDLE or RESP is ignored.
- Request changes:
  - A req bit dropping during BUSY does not abort the access. The response is still pulsed.
  - Request fields changing during BUSY are ignored; the values latched at grant are used.

Test Plan:
- Rst=1 for 2 cycles with both req=1 -> all outputs 0, o_grant=00. After release, D is granted first, with mem_req=1 one cycle after the first sampled cycle.
- Single I read, addr=0x100, mem_ack 3 cycles after mem_req with rdata=0x12345678 -> Icache_bus_in=33'h1_12345678 for exactly 1 cycle, the cycle after mem_ack. Dcache_bus_in stays 0.
- D write, addr=0x40, wdata=0xA5A5A5A5, immediate ack -> mem_we=1, mem_addr=0x40, mem_wdata=0xA5A5A5A5 held until ack. Dcache_bus_in=33'h1_00000000 for 1 cycle.
- Both requesters continuously requesting, D_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I. starve_cnt is 0 after each I grant.
- TIMEOUT=8, no mem_ack -> mem_req drops after 8 BUSY cycles. The owner gets {1, 0xDEADBEEF}. o_timeout_err=1 and stays 1 through later successful accesses until Rst.
- Rst asserted mid-BUSY, then a late mem_ack arrives -> state IDLE, no ack pulse to either requester, mem_req=0.
